// File: rtl/level_sensor_filter.sv
// Tank-level probe conditioner: per-probe 2-flop sync + debounce, thermometer consistency FSM.
// Define LEVEL_FAULT_LATCH_EN to make FAULT sticky (only reset leaves it).
module level_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic rawHigh,
    input  logic rawMedium,
    input  logic rawLow,
    output logic highLevel,
    output logic mediumLevel,
    output logic lowLevel,
    output logic levelValid,
    output logic sensorFault,
    output logic levelChanged
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    // INIT counts to DEBOUNCE_CYCLES+2 on the shared timer, so widen it when needed.
    localparam int IW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam int TW = (FW > IW) ? FW : IW;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_VALID,
        ST_SUSPECT,
        ST_FAULT
    } state_t;

    logic [2:0] raw_vec;
    logic [2:0] deb_vec;

    assign raw_vec = {rawHigh, rawMedium, rawLow};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_probe
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic          deb_q, deb_d;
            logic [DW-1:0] cnt_q, cnt_d;

            always_comb begin
                sync1_d = raw_vec[gi];
                sync2_d = sync1_q;
                deb_d   = deb_q;
                cnt_d   = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d = ~deb_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign deb_vec[gi] = deb_q;
        end
    endgenerate

    logic consistent;

    always_comb begin
        consistent = 1'b0;
        case (deb_vec)
            3'b000, 3'b001, 3'b011, 3'b111: consistent = 1'b1;
            default:                        consistent = 1'b0;
        endcase
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    out_q, out_d;
    logic          changed_q, changed_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        out_d   = out_q;
        case (state_q)
            ST_INIT: begin
                if (timer_q == TW'(DEBOUNCE_CYCLES + 2)) begin
                    timer_d = '0;
                    if (consistent) begin
                        state_d = ST_VALID;
                        out_d   = deb_vec;
                    end else begin
                        state_d = ST_SUSPECT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_VALID: begin
                timer_d = '0;
                if (consistent) begin
                    out_d = deb_vec;
                end else begin
                    state_d = ST_SUSPECT;
                end
            end
            ST_SUSPECT: begin
                if (consistent) begin
                    state_d = ST_VALID;
                    out_d   = deb_vec;
                    timer_d = '0;
                end else if (timer_q == TW'(FAULT_CYCLES - 1)) begin
                    state_d = ST_FAULT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_FAULT: begin
`ifdef LEVEL_FAULT_LATCH_EN
                timer_d = '0;
`else
                // Recovery needs an unbroken run of consistent cycles.
                if (!consistent) begin
                    timer_d = '0;
                end else if (timer_q == TW'(FAULT_CYCLES - 1)) begin
                    state_d = ST_VALID;
                    out_d   = deb_vec;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
                timer_d = '0;
                out_d   = 3'b000;
            end
        endcase
        changed_d = (out_d != out_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            timer_q   <= '0;
            out_q     <= 3'b000;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign highLevel    = out_q[2];
    assign mediumLevel  = out_q[1];
    assign lowLevel     = out_q[0];
    assign levelValid   = (state_q == ST_VALID);
    assign sensorFault  = (state_q == ST_FAULT);
    assign levelChanged = changed_q;

endmodule
